// File: rtl/order_map.sv
// Direct-mapped order table translating add/replace/exec/cancel/delete
// instructions into per-price-level book effects (add or subtract shares).
module order_map #(
  parameter int ORDER_ID_BITS = 32,
  parameter int PRICE_BITS    = 32,
  parameter int QUANTITY_BITS = 32,
  parameter int MAX_ORDERS    = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [ORDER_ID_BITS-1:0] in_order_id,
  input  logic [ORDER_ID_BITS-1:0] in_new_order_id,
  input  logic                     in_side,
  input  logic [PRICE_BITS-1:0]    in_price,
  input  logic [QUANTITY_BITS-1:0] in_quantity,
  output logic                     eff_valid,
  input  logic                     eff_ready,
  output logic                     eff_side,
  output logic [PRICE_BITS-1:0]    eff_price,
  output logic [QUANTITY_BITS-1:0] eff_quantity,
  output logic                     eff_dec,
  output logic                     err
);
  localparam int IDX = $clog2(MAX_ORDERS);

  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_ADDWMPID = 4'h4;
  localparam logic [3:0] OP_REPLACE  = 4'h5;
  localparam logic [3:0] OP_DELETE   = 4'h9;

  typedef enum logic [1:0] {IDLE, LOOKUP, EMIT, EMIT2} state_t;
  state_t state, state_next;

  logic [MAX_ORDERS-1:0]    valid_bits;
  logic [ORDER_ID_BITS-1:0] tag_mem   [MAX_ORDERS];
  logic                     side_mem  [MAX_ORDERS];
  logic [PRICE_BITS-1:0]    price_mem [MAX_ORDERS];
  logic [QUANTITY_BITS-1:0] qty_mem   [MAX_ORDERS];

  logic [3:0]               op_r;
  logic [ORDER_ID_BITS-1:0] id_r, new_id_r;
  logic                     side_r;
  logic [PRICE_BITS-1:0]    price_r;
  logic [QUANTITY_BITS-1:0] qty_r;

  logic [IDX-1:0]           old_slot, new_slot;
  logic                     ent_side;
  logic [PRICE_BITS-1:0]    ent_price;
  logic [QUANTITY_BITS-1:0] ent_qty, take, rem;
  logic                     hit, new_busy, is_add, fail, commit;

  function automatic logic is_book(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_DELETE);
  endfunction

  assign old_slot  = id_r[IDX-1:0];
  assign new_slot  = new_id_r[IDX-1:0];
  assign ent_side  = side_mem[old_slot];
  assign ent_price = price_mem[old_slot];
  assign ent_qty   = qty_mem[old_slot];
  assign hit       = valid_bits[old_slot] && (tag_mem[old_slot] == id_r);
  // The old slot is freed by the replace itself, so reusing it is legal.
  assign new_busy  = valid_bits[new_slot] && (new_slot != old_slot);
  assign is_add    = (op_r == OP_ADD) || (op_r == OP_ADDWMPID);
  assign take      = (qty_r < ent_qty) ? qty_r : ent_qty;
  assign rem       = ent_qty - take;
  assign commit    = (state == LOOKUP) && !fail;

  assign in_ready  = (state == IDLE) && rst_n;
  assign eff_valid = (state == EMIT) || (state == EMIT2);

  always_comb begin
    state_next = state;
    fail       = 1'b0;
    case (state)
      IDLE:   if (in_valid && is_book(in_op)) state_next = LOOKUP;
      LOOKUP: begin
        if (is_add)                  fail = valid_bits[old_slot];
        else if (op_r == OP_REPLACE) fail = !hit || new_busy;
        else                         fail = !hit;
        state_next = fail ? IDLE : EMIT;
      end
      EMIT:   if (eff_ready) state_next = (op_r == OP_REPLACE) ? EMIT2 : IDLE;
      EMIT2:  if (eff_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid_bits   <= '0;
      err          <= 1'b0;
      eff_side     <= 1'b0;
      eff_price    <= '0;
      eff_quantity <= '0;
      eff_dec      <= 1'b0;
    end else begin
      state <= state_next;
      err   <= (state == LOOKUP) && fail;
      if (commit) begin
        if (is_add) begin
          valid_bits[old_slot] <= 1'b1;
          eff_side     <= side_r;
          eff_price    <= price_r;
          eff_quantity <= qty_r;
          eff_dec      <= 1'b0;
        end else if (op_r == OP_REPLACE || op_r == OP_DELETE) begin
          valid_bits[old_slot] <= 1'b0;
          if (op_r == OP_REPLACE) valid_bits[new_slot] <= 1'b1;
          eff_side     <= ent_side;
          eff_price    <= ent_price;
          eff_quantity <= ent_qty;
          eff_dec      <= 1'b1;
        end else begin
          if (rem == '0) valid_bits[old_slot] <= 1'b0;
          eff_side     <= ent_side;
          eff_price    <= ent_price;
          eff_quantity <= take;
          eff_dec      <= 1'b1;
        end
      end else if (state == EMIT && eff_ready && op_r == OP_REPLACE) begin
        eff_price    <= price_r;
        eff_quantity <= qty_r;
        eff_dec      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      op_r     <= in_op;
      id_r     <= in_order_id;
      new_id_r <= in_new_order_id;
      side_r   <= in_side;
      price_r  <= in_price;
      qty_r    <= in_quantity;
    end
    if (commit) begin
      if (is_add) begin
        tag_mem[old_slot]   <= id_r;
        side_mem[old_slot]  <= side_r;
        price_mem[old_slot] <= price_r;
        qty_mem[old_slot]   <= qty_r;
      end else if (op_r == OP_REPLACE) begin
        tag_mem[new_slot]   <= new_id_r;
        side_mem[new_slot]  <= ent_side;
        price_mem[new_slot] <= price_r;
        qty_mem[new_slot]   <= qty_r;
      end else if (op_r != OP_DELETE) begin
        qty_mem[old_slot]   <= rem;
      end
    end
  end
endmodule

// File: tb/tb_order_map.sv
// Directed bench for order_map: reset, add/exec/cancel/delete, replace,
// slot collision, backpressure and reset during the second replace effect.
module tb_order_map;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'h0;
  logic [31:0] in_order_id = '0, in_new_order_id = '0;
  logic        in_side = 1'b0;
  logic [31:0] in_price = '0, in_quantity = '0;
  logic        eff_valid, eff_ready = 1'b1, eff_side, eff_dec, err;
  logic [31:0] eff_price, eff_quantity;

  int checks = 0;
  int errors = 0;
  logic [67:0] exp;
  wire  [67:0] obs = {eff_valid, eff_side, eff_price, eff_quantity, eff_dec, err};

  order_map dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_order_id(in_order_id), .in_new_order_id(in_new_order_id),
    .in_side(in_side), .in_price(in_price), .in_quantity(in_quantity),
    .eff_valid(eff_valid), .eff_ready(eff_ready), .eff_side(eff_side),
    .eff_price(eff_price), .eff_quantity(eff_quantity), .eff_dec(eff_dec), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [67:0] effv(input logic s, input logic [31:0] p,
                                       input logic [31:0] q, input logic d);
    return {1'b1, s, p, q, d, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] id, input logic [31:0] nid,
                       input logic s, input logic [31:0] p, input logic [31:0] q);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_order_id = id; in_new_order_id = nid;
    in_side = s; in_price = p; in_quantity = q;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (obs !== 68'd0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_outputs got %h rdy %b exp 0 rdy 0", obs, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add_exec_cancel();
    issue(4'h3, 5, 0, 1'b0, 100, 300);
    checks++; if (eff_valid !== 1'b0) begin errors++;
      $display("FAIL add_latency_c1 got %b exp 0", eff_valid); end
    step();
    exp = effv(1'b0, 100, 300, 1'b0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL add_eff got %h exp %h", obs, exp); end
    step();
    checks++; if ({eff_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL add_done got %b exp 01", {eff_valid, in_ready}); end
    issue(4'h6, 5, 0, 1'b0, 0, 100); step();
    exp = effv(1'b0, 100, 100, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL exec_eff got %h exp %h", obs, exp); end
    step();
    issue(4'h8, 5, 0, 1'b0, 0, 500); step();
    exp = effv(1'b0, 100, 200, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL cancel_clip got %h exp %h", obs, exp); end
    step();
    issue(4'h9, 5, 0, 1'b0, 0, 0); step();
    checks++; if ({eff_valid, err, in_ready} !== 3'b011) begin errors++;
      $display("FAIL delete_miss got %b exp 011", {eff_valid, err, in_ready}); end
    step();
    checks++; if ({eff_valid, err} !== 2'b00) begin errors++;
      $display("FAIL err_single_pulse got %b exp 00", {eff_valid, err}); end
  endtask

  task automatic test_zero_and_nonbook();
    issue(4'h4, 12, 0, 1'b1, 9, 0); step();
    exp = effv(1'b1, 9, 0, 1'b0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL add_zero got %h exp %h", obs, exp); end
    step();
    issue(4'h7, 12, 0, 1'b0, 0, 5); step();
    exp = effv(1'b1, 9, 0, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL exec_zero got %h exp %h", obs, exp); end
    step();
    issue(4'h9, 12, 0, 1'b0, 0, 0); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL zero_cleared got %b exp 01", {eff_valid, err}); end
    issue(4'h1, 12, 0, 1'b0, 0, 0);
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL nonbook_ready got %b exp 1", in_ready); end
    step();
    checks++; if ({eff_valid, err, in_ready} !== 3'b001) begin errors++;
      $display("FAIL nonbook_effect got %b exp 001", {eff_valid, err, in_ready}); end
  endtask

  task automatic test_replace();
    issue(4'h3, 5, 0, 1'b1, 50, 10); step();
    exp = effv(1'b1, 50, 10, 1'b0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL rep_add got %h exp %h", obs, exp); end
    step();
    issue(4'h5, 5, 7, 1'b0, 51, 20); step();
    exp = effv(1'b1, 50, 10, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL rep_emit1 got %h exp %h", obs, exp); end
    step();
    exp = effv(1'b1, 51, 20, 1'b0);
    checks++; if (obs !== exp || in_ready !== 1'b0) begin errors++;
      $display("FAIL rep_emit2 got %h rdy %b exp %h rdy 0", obs, in_ready, exp); end
    step();
    checks++; if ({eff_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL rep_done got %b exp 01", {eff_valid, in_ready}); end
    issue(4'h9, 7, 0, 1'b0, 0, 0); step();
    exp = effv(1'b1, 51, 20, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL rep_del_new got %h exp %h", obs, exp); end
    step();
    issue(4'h9, 5, 0, 1'b0, 0, 0); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL rep_old_gone got %b exp 01", {eff_valid, err}); end
    // same-slot replace: 1044 maps onto slot 20
    issue(4'h3, 20, 0, 1'b0, 10, 3); step(); step();
    issue(4'h5, 20, 1044, 1'b1, 11, 6); step();
    exp = effv(1'b0, 10, 3, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL same_slot_e1 got %h exp %h", obs, exp); end
    step();
    exp = effv(1'b0, 11, 6, 1'b0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL same_slot_e2 got %h exp %h", obs, exp); end
    step();
    issue(4'h9, 1044, 0, 1'b0, 0, 0); step();
    exp = effv(1'b0, 11, 6, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL same_slot_del got %h exp %h", obs, exp); end
    step();
    issue(4'h3, 30, 0, 1'b0, 1, 1); step(); step();
    issue(4'h3, 31, 0, 1'b0, 2, 2); step(); step();
    issue(4'h5, 30, 31, 1'b0, 3, 3); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL rep_busy_err got %b exp 01", {eff_valid, err}); end
    issue(4'h9, 30, 0, 1'b0, 0, 0); step();
    exp = effv(1'b0, 1, 1, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL rep_busy_intact got %h exp %h", obs, exp); end
    step();
    issue(4'h9, 31, 0, 1'b0, 0, 0); step(); step();
  endtask

  task automatic test_collision();
    issue(4'h3, 5, 0, 1'b0, 100, 300); step(); step();
    issue(4'h3, 1029, 0, 1'b1, 7, 7); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL collide_add got %b exp 01", {eff_valid, err}); end
    issue(4'h6, 1029, 0, 1'b0, 0, 1); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL tag_mismatch got %b exp 01", {eff_valid, err}); end
    issue(4'h9, 5, 0, 1'b0, 0, 0); step();
    exp = effv(1'b0, 100, 300, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL collide_intact got %h exp %h", obs, exp); end
    step();
  endtask

  task automatic test_backpressure();
    eff_ready = 1'b0;
    issue(4'h3, 9, 0, 1'b0, 77, 4); step();
    exp = effv(1'b0, 77, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (obs !== exp || in_ready !== 1'b0) begin errors++;
        $display("FAIL stall_hold%0d got %h rdy %b exp %h rdy 0", i, obs, in_ready, exp); end
    end
    @(negedge clk); eff_ready = 1'b1;
    step();
    checks++; if ({eff_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL stall_release got %b exp 01", {eff_valid, in_ready}); end
    issue(4'h9, 9, 0, 1'b0, 0, 0); step();
    exp = effv(1'b0, 77, 4, 1'b1);
    checks++; if (obs !== exp) begin errors++; $display("FAIL stall_single got %h exp %h", obs, exp); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(4'h3, 40, 0, 1'b1, 60, 8); step(); step();
    issue(4'h5, 40, 41, 1'b0, 61, 9); step(); step();
    exp = effv(1'b1, 61, 9, 1'b0);
    checks++; if (obs !== exp) begin errors++; $display("FAIL mid_emit2 got %h exp %h", obs, exp); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs !== 68'd0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL mid_async got %h rdy %b exp 0 rdy 0", obs, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if ({eff_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL mid_no_second got %b exp 01", {eff_valid, in_ready}); end
    issue(4'h6, 40, 0, 1'b0, 0, 1); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL mid_old_gone got %b exp 01", {eff_valid, err}); end
    issue(4'h6, 41, 0, 1'b0, 0, 1); step();
    checks++; if ({eff_valid, err} !== 2'b01) begin errors++;
      $display("FAIL mid_new_gone got %b exp 01", {eff_valid, err}); end
    step();
  endtask

  initial begin
    test_reset();
    test_add_exec_cancel();
    test_zero_and_nonbook();
    test_replace();
    test_collision();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
